// File: rtl/rvfi_collector.sv
// rvfi_collector: collects retired instructions into an in-order queue.
// Loads retired before their data has returned wait in the queue until
// ld_valid arrives. Complete head entries are emitted as registered RVFI
// packets, one per cycle, in retire order.
// Optional feature macro: RVFI_COLLECTOR_INTR_EN. When it is defined,
// rvfi_intr marks the first packet after a packet with rvfi_trap set.
module rvfi_collector #(
  parameter int DEPTH = 4
) (
  input  logic        rvfi_ext_clk,
  input  logic        rvfi_ext_reset_n,
  input  logic        ret_valid,
  output logic        ret_ready,
  input  logic [31:0] ret_insn,
  input  logic        ret_trap,
  input  logic        ret_halt,
  input  logic [1:0]  ret_mode,
  input  logic [4:0]  ret_rs1_addr,
  input  logic [4:0]  ret_rs2_addr,
  input  logic [4:0]  ret_rd_addr,
  input  logic [31:0] ret_rs1_rdata,
  input  logic [31:0] ret_rs2_rdata,
  input  logic [31:0] ret_rd_wdata,
  input  logic [31:0] ret_pc_rdata,
  input  logic [31:0] ret_pc_wdata,
  input  logic [31:0] ret_mem_addr,
  input  logic [31:0] ret_mem_wdata,
  input  logic [3:0]  ret_mem_rmask,
  input  logic [3:0]  ret_mem_wmask,
  input  logic        ret_ld_pending,
  input  logic        ld_valid,
  input  logic [31:0] ld_mem_rdata,
  input  logic [31:0] ld_rd_wdata,
  output logic        rvfi_valid,
  output logic [63:0] rvfi_order,
  output logic [31:0] rvfi_insn,
  output logic        rvfi_trap,
  output logic        rvfi_halt,
  output logic        rvfi_intr,
  output logic [1:0]  rvfi_mode,
  output logic [1:0]  rvfi_ixl,
  output logic [4:0]  rvfi_rs1_addr,
  output logic [4:0]  rvfi_rs2_addr,
  output logic [4:0]  rvfi_rd_addr,
  output logic [31:0] rvfi_rs1_rdata,
  output logic [31:0] rvfi_rs2_rdata,
  output logic [31:0] rvfi_rd_wdata,
  output logic [31:0] rvfi_pc_rdata,
  output logic [31:0] rvfi_pc_wdata,
  output logic [31:0] rvfi_mem_addr,
  output logic [3:0]  rvfi_mem_rmask,
  output logic [3:0]  rvfi_mem_wmask,
  output logic [31:0] rvfi_mem_rdata,
  output logic [31:0] rvfi_mem_wdata,
  output logic        proto_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic [1:0]  mode;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic [4:0]  rdAddr;
    logic [31:0] rs1Rdata;
    logic [31:0] rs2Rdata;
    logic [31:0] rdWdata;
    logic [31:0] pcRdata;
    logic [31:0] pcWdata;
    logic [31:0] memAddr;
    logic [3:0]  memRmask;
    logic [3:0]  memWmask;
    logic [31:0] memRdata;
    logic [31:0] memWdata;
  } entry_t;

  entry_t             entryMem_q [DEPTH];
  logic [DEPTH-1:0]   complete_q, complete_d;
  logic [PTR_W-1:0]   headPtr_q, headPtr_d;
  logic [PTR_W-1:0]   tailPtr_q, tailPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [63:0]        orderCnt_q, orderCnt_d;
  logic               protoErr_q, protoErr_d;
  logic               valid_q;
  logic [63:0]        outOrder_q;
  entry_t             out_q;

  logic               accept;
  entry_t             inEntry;
  logic               inComplete;
  logic               ldHit;
  logic [PTR_W-1:0]   ldIdx;
  logic [PTR_W-1:0]   scanIdx;
  logic               ldToQueue;
  logic               ldToIn;
  logic               ldBad;
  entry_t             headView;
  logic               emit;

  // Ready depends only on the registered occupancy so it never waits on a same-cycle emission.
  assign ret_ready = (count_q != CNT_W'(DEPTH));

  // Route load data, build the incoming entry and decide what the head presents this cycle.
  always_comb begin
    accept = ret_valid && ret_ready;

    inEntry.insn     = ret_insn;
    inEntry.trap     = ret_trap;
    inEntry.halt     = ret_halt;
    inEntry.mode     = ret_mode;
    inEntry.rs1Addr  = ret_rs1_addr;
    inEntry.rs2Addr  = ret_rs2_addr;
    inEntry.rdAddr   = ret_rd_addr;
    inEntry.rs1Rdata = ret_rs1_rdata;
    inEntry.rs2Rdata = ret_rs2_rdata;
    inEntry.rdWdata  = ret_rd_wdata;
    inEntry.pcRdata  = ret_pc_rdata;
    inEntry.pcWdata  = ret_pc_wdata;
    inEntry.memAddr  = ret_mem_addr;
    inEntry.memRmask = ret_mem_rmask;
    inEntry.memWmask = ret_mem_wmask;
    inEntry.memRdata = 32'd0;
    inEntry.memWdata = ret_mem_wdata;
    inComplete       = !ret_ld_pending;

    ldHit   = 1'b0;
    ldIdx   = '0;
    scanIdx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scanIdx = headPtr_q + PTR_W'(i);
      if (!ldHit && (CNT_W'(i) < count_q) && !complete_q[scanIdx]) begin
        ldHit = 1'b1;
        ldIdx = scanIdx;
      end
    end

    ldToQueue = ld_valid && ldHit;
    ldToIn    = ld_valid && !ldHit && accept && ret_ld_pending;
    ldBad     = ld_valid && !ldToQueue && !ldToIn;

    if (ldToIn) begin
      inEntry.rdWdata  = ld_rd_wdata;
      inEntry.memRdata = ld_mem_rdata;
      inComplete       = 1'b1;
    end

    if (count_q == '0) begin
      headView = inEntry;
      emit     = accept && inComplete;
    end else begin
      headView = entryMem_q[headPtr_q];
      emit     = complete_q[headPtr_q];
      if (ldToQueue && (ldIdx == headPtr_q)) begin
        headView.rdWdata  = ld_rd_wdata;
        headView.memRdata = ld_mem_rdata;
        emit              = 1'b1;
      end
    end
  end

  // Next-state for pointers, occupancy, completion flags, order counter and error flag.
  always_comb begin
    headPtr_d  = headPtr_q;
    tailPtr_d  = tailPtr_q;
    count_d    = count_q;
    complete_d = complete_q;
    orderCnt_d = orderCnt_q;
    protoErr_d = protoErr_q | ldBad;

    if (accept) begin
      tailPtr_d           = tailPtr_q + PTR_W'(1);
      complete_d[tailPtr_q] = inComplete;
    end
    if (ldToQueue) begin
      complete_d[ldIdx] = 1'b1;
    end
    if (emit) begin
      headPtr_d  = headPtr_q + PTR_W'(1);
      orderCnt_d = orderCnt_q + 64'd1;
    end
    if (accept && !emit) begin
      count_d = count_q + CNT_W'(1);
    end else if (!accept && emit) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Queue control state and the registered packet outputs; reset flushes everything.
  always_ff @(posedge rvfi_ext_clk or negedge rvfi_ext_reset_n) begin
    if (!rvfi_ext_reset_n) begin
      headPtr_q  <= '0;
      tailPtr_q  <= '0;
      count_q    <= '0;
      complete_q <= '0;
      orderCnt_q <= 64'd0;
      protoErr_q <= 1'b0;
      valid_q    <= 1'b0;
      outOrder_q <= 64'd0;
      out_q      <= '0;
    end else begin
      headPtr_q  <= headPtr_d;
      tailPtr_q  <= tailPtr_d;
      count_q    <= count_d;
      complete_q <= complete_d;
      orderCnt_q <= orderCnt_d;
      protoErr_q <= protoErr_d;
      valid_q    <= emit;
      if (emit) begin
        out_q      <= headView;
        outOrder_q <= orderCnt_q;
      end
    end
  end

  // Entry payload storage; stale slots are harmless because the occupancy count guards them.
  always_ff @(posedge rvfi_ext_clk) begin
    if (accept) begin
      entryMem_q[tailPtr_q] <= inEntry;
    end
    if (ldToQueue) begin
      entryMem_q[ldIdx].rdWdata  <= ld_rd_wdata;
      entryMem_q[ldIdx].memRdata <= ld_mem_rdata;
    end
  end

`ifdef RVFI_COLLECTOR_INTR_EN
  logic lastTrap_q;
  logic intr_q;

  // Remember whether the previous packet trapped so the next packet is flagged as an interrupt entry.
  always_ff @(posedge rvfi_ext_clk or negedge rvfi_ext_reset_n) begin
    if (!rvfi_ext_reset_n) begin
      lastTrap_q <= 1'b0;
      intr_q     <= 1'b0;
    end else if (emit) begin
      intr_q     <= lastTrap_q;
      lastTrap_q <= headView.trap;
    end
  end

  assign rvfi_intr = intr_q;
`else
  assign rvfi_intr = 1'b0;
`endif

  assign rvfi_valid     = valid_q;
  assign rvfi_order     = outOrder_q;
  assign rvfi_insn      = out_q.insn;
  assign rvfi_trap      = out_q.trap;
  assign rvfi_halt      = out_q.halt;
  assign rvfi_mode      = out_q.mode;
  assign rvfi_ixl       = 2'b01;
  assign rvfi_rs1_addr  = out_q.rs1Addr;
  assign rvfi_rs2_addr  = out_q.rs2Addr;
  assign rvfi_rd_addr   = out_q.rdAddr;
  assign rvfi_rs1_rdata = out_q.rs1Rdata;
  assign rvfi_rs2_rdata = out_q.rs2Rdata;
  assign rvfi_rd_wdata  = out_q.rdWdata;
  assign rvfi_pc_rdata  = out_q.pcRdata;
  assign rvfi_pc_wdata  = out_q.pcWdata;
  assign rvfi_mem_addr  = out_q.memAddr;
  assign rvfi_mem_rmask = out_q.memRmask;
  assign rvfi_mem_wmask = out_q.memWmask;
  assign rvfi_mem_rdata = out_q.memRdata;
  assign rvfi_mem_wdata = out_q.memWdata;
  assign proto_err      = protoErr_q;

endmodule

// File: tb/tb_rvfi_collector.sv
// tb_rvfi_collector: self-checking bench for rvfi_collector.
// A directed table covers in-order emission and a late load, hand-written
// sequences cover the full queue, stray load data, reset and the interrupt
// flag, and a random phase is checked against a queue-based model.
module tb_rvfi_collector;

  localparam int DEPTH = 4;
`ifdef RVFI_COLLECTOR_INTR_EN
  localparam bit INTR_EN = 1'b1;
`else
  localparam bit INTR_EN = 1'b0;
`endif

  logic        rvfi_ext_clk = 1'b0;
  logic        rvfi_ext_reset_n = 1'b0;
  logic        ret_valid = 1'b0;
  logic        ret_ready;
  logic [31:0] ret_insn = '0;
  logic        ret_trap = 1'b0;
  logic        ret_halt = 1'b0;
  logic [1:0]  ret_mode = '0;
  logic [4:0]  ret_rs1_addr = '0;
  logic [4:0]  ret_rs2_addr = '0;
  logic [4:0]  ret_rd_addr = '0;
  logic [31:0] ret_rs1_rdata = '0;
  logic [31:0] ret_rs2_rdata = '0;
  logic [31:0] ret_rd_wdata = '0;
  logic [31:0] ret_pc_rdata = '0;
  logic [31:0] ret_pc_wdata = '0;
  logic [31:0] ret_mem_addr = '0;
  logic [31:0] ret_mem_wdata = '0;
  logic [3:0]  ret_mem_rmask = '0;
  logic [3:0]  ret_mem_wmask = '0;
  logic        ret_ld_pending = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_mem_rdata = '0;
  logic [31:0] ld_rd_wdata = '0;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap;
  logic        rvfi_halt;
  logic        rvfi_intr;
  logic [1:0]  rvfi_mode;
  logic [1:0]  rvfi_ixl;
  logic [4:0]  rvfi_rs1_addr;
  logic [4:0]  rvfi_rs2_addr;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rs1_rdata;
  logic [31:0] rvfi_rs2_rdata;
  logic [31:0] rvfi_rd_wdata;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_pc_wdata;
  logic [31:0] rvfi_mem_addr;
  logic [3:0]  rvfi_mem_rmask;
  logic [3:0]  rvfi_mem_wmask;
  logic [31:0] rvfi_mem_rdata;
  logic [31:0] rvfi_mem_wdata;
  logic        proto_err;

  int checkCount = 0;
  int errorCount = 0;

  rvfi_collector #(.DEPTH(DEPTH)) dut (
    .rvfi_ext_clk     (rvfi_ext_clk),
    .rvfi_ext_reset_n (rvfi_ext_reset_n),
    .ret_valid        (ret_valid),
    .ret_ready        (ret_ready),
    .ret_insn         (ret_insn),
    .ret_trap         (ret_trap),
    .ret_halt         (ret_halt),
    .ret_mode         (ret_mode),
    .ret_rs1_addr     (ret_rs1_addr),
    .ret_rs2_addr     (ret_rs2_addr),
    .ret_rd_addr      (ret_rd_addr),
    .ret_rs1_rdata    (ret_rs1_rdata),
    .ret_rs2_rdata    (ret_rs2_rdata),
    .ret_rd_wdata     (ret_rd_wdata),
    .ret_pc_rdata     (ret_pc_rdata),
    .ret_pc_wdata     (ret_pc_wdata),
    .ret_mem_addr     (ret_mem_addr),
    .ret_mem_wdata    (ret_mem_wdata),
    .ret_mem_rmask    (ret_mem_rmask),
    .ret_mem_wmask    (ret_mem_wmask),
    .ret_ld_pending   (ret_ld_pending),
    .ld_valid         (ld_valid),
    .ld_mem_rdata     (ld_mem_rdata),
    .ld_rd_wdata      (ld_rd_wdata),
    .rvfi_valid       (rvfi_valid),
    .rvfi_order       (rvfi_order),
    .rvfi_insn        (rvfi_insn),
    .rvfi_trap        (rvfi_trap),
    .rvfi_halt        (rvfi_halt),
    .rvfi_intr        (rvfi_intr),
    .rvfi_mode        (rvfi_mode),
    .rvfi_ixl         (rvfi_ixl),
    .rvfi_rs1_addr    (rvfi_rs1_addr),
    .rvfi_rs2_addr    (rvfi_rs2_addr),
    .rvfi_rd_addr     (rvfi_rd_addr),
    .rvfi_rs1_rdata   (rvfi_rs1_rdata),
    .rvfi_rs2_rdata   (rvfi_rs2_rdata),
    .rvfi_rd_wdata    (rvfi_rd_wdata),
    .rvfi_pc_rdata    (rvfi_pc_rdata),
    .rvfi_pc_wdata    (rvfi_pc_wdata),
    .rvfi_mem_addr    (rvfi_mem_addr),
    .rvfi_mem_rmask   (rvfi_mem_rmask),
    .rvfi_mem_wmask   (rvfi_mem_wmask),
    .rvfi_mem_rdata   (rvfi_mem_rdata),
    .rvfi_mem_wdata   (rvfi_mem_wdata),
    .proto_err        (proto_err)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 rvfi_ext_clk = ~rvfi_ext_clk;

  // Safety net so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic [1:0]  mode;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic [4:0]  rdAddr;
    logic [31:0] rs1Rdata;
    logic [31:0] rs2Rdata;
    logic [31:0] rdWdata;
    logic [31:0] pcRdata;
    logic [31:0] pcWdata;
    logic [31:0] memAddr;
    logic [3:0]  memRmask;
    logic [3:0]  memWmask;
    logic [31:0] memRdata;
    logic [31:0] memWdata;
    bit          pending;
    bit          complete;
  } pkt_t;

  typedef struct {
    bit          v;
    bit          pend;
    logic [31:0] pc;
    bit          ldv;
    logic [31:0] ldRd;
    bit          expValid;
    logic [31:0] expPc;
    logic [63:0] expOrder;
    logic [31:0] expRd;
    bit          expReady;
  } vec_t;

  // Reference model state: a plain queue of retired instructions in retire order.
  pkt_t        modelQ[$];
  pkt_t        expPkt;
  bit          expValid;
  bit          expReady;
  bit          expIntr;
  bit          modelErr;
  bit          modelLastTrap;
  logic [63:0] modelOrder;
  logic [63:0] expOrder;

  // Compare one value and report a failure line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle worth of retire and load inputs.
  task automatic applyStimulus(input bit v, input pkt_t p, input bit ldv,
                               input logic [31:0] ldMem, input logic [31:0] ldRd);
    ret_valid      = v;
    ret_insn       = p.insn;
    ret_trap       = p.trap;
    ret_halt       = p.halt;
    ret_mode       = p.mode;
    ret_rs1_addr   = p.rs1Addr;
    ret_rs2_addr   = p.rs2Addr;
    ret_rd_addr    = p.rdAddr;
    ret_rs1_rdata  = p.rs1Rdata;
    ret_rs2_rdata  = p.rs2Rdata;
    ret_rd_wdata   = p.rdWdata;
    ret_pc_rdata   = p.pcRdata;
    ret_pc_wdata   = p.pcWdata;
    ret_mem_addr   = p.memAddr;
    ret_mem_wdata  = p.memWdata;
    ret_mem_rmask  = p.memRmask;
    ret_mem_wmask  = p.memWmask;
    ret_ld_pending = p.pending;
    ld_valid       = ldv;
    ld_mem_rdata   = ldMem;
    ld_rd_wdata    = ldRd;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge rvfi_ext_clk);
    #1;
  endtask

  // Simple recognisable instruction built around a PC value.
  function automatic pkt_t mkPkt(input logic [31:0] pc, input bit pend, input bit trap);
    pkt_t p;
    p = '{default: '0};
    p.insn     = 32'h0000_0013 ^ pc;
    p.trap     = trap;
    p.mode     = 2'b11;
    p.rs1Addr  = 5'd1;
    p.rs2Addr  = 5'd2;
    p.rdAddr   = 5'd3;
    p.rs1Rdata = 32'h1111_0000 | pc;
    p.rs2Rdata = 32'h2222_0000 | pc;
    p.rdWdata  = 32'h1000_0000 | pc;
    p.pcRdata  = pc;
    p.pcWdata  = pc + 32'd4;
    p.memAddr  = 32'h8000_0000 | pc;
    p.memRmask = pend ? 4'hf : 4'h0;
    p.pending  = pend;
    p.complete = !pend;
    return p;
  endfunction

  function automatic pkt_t randPkt();
    pkt_t p;
    p = '{default: '0};
    p.insn     = $urandom;
    p.trap     = ($urandom_range(0, 6) == 0);
    p.halt     = ($urandom_range(0, 15) == 0);
    p.mode     = 2'($urandom_range(0, 3));
    p.rs1Addr  = 5'($urandom);
    p.rs2Addr  = 5'($urandom);
    p.rdAddr   = 5'($urandom);
    p.rs1Rdata = $urandom;
    p.rs2Rdata = $urandom;
    p.rdWdata  = $urandom;
    p.pcRdata  = $urandom;
    p.pcWdata  = $urandom;
    p.memAddr  = $urandom;
    p.memRmask = 4'($urandom);
    p.memWmask = 4'($urandom);
    p.memWdata = $urandom;
    p.pending  = ($urandom_range(0, 2) == 0);
    p.complete = !p.pending;
    return p;
  endfunction

  // Hold reset for two edges, checking the cleared outputs, then release between edges.
  task automatic applyReset();
    pkt_t idle;
    idle = '{default: '0};
    applyStimulus(1'b0, idle, 1'b0, 32'd0, 32'd0);
    #2;
    rvfi_ext_reset_n = 1'b0;
    #1;
    checkOutput("reset valid", rvfi_valid, 1'b0);
    checkOutput("reset order", rvfi_order, 64'd0);
    checkOutput("reset pc_rdata", rvfi_pc_rdata, 32'd0);
    checkOutput("reset insn", rvfi_insn, 32'd0);
    checkOutput("reset rd_wdata", rvfi_rd_wdata, 32'd0);
    checkOutput("reset ixl", rvfi_ixl, 2'b01);
    checkOutput("reset intr", rvfi_intr, 1'b0);
    checkOutput("reset proto_err", proto_err, 1'b0);
    tick();
    tick();
    checkOutput("reset ready", ret_ready, 1'b1);
    rvfi_ext_reset_n = 1'b1;
  endtask

  // Model reset mirrors the cleared outputs of the collector.
  task automatic modelReset();
    modelQ.delete();
    expPkt        = '{default: '0};
    expValid      = 1'b0;
    expReady      = 1'b1;
    expIntr       = 1'b0;
    modelErr      = 1'b0;
    modelLastTrap = 1'b0;
    modelOrder    = 64'd0;
    expOrder      = 64'd0;
  endtask

  // One cycle of the reference model: accept, route load data, emit the oldest complete packet.
  task automatic modelStep(input bit v, input pkt_t inP, input bit ldv,
                           input logic [31:0] ldMem, input logic [31:0] ldRd);
    bit ready;
    bit acc;
    bit applied;
    ready = (modelQ.size() < DEPTH);
    checkOutput("rand ready", ret_ready, ready);
    acc = v && ready;
    applied = 1'b0;
    if (ldv) begin
      foreach (modelQ[i]) begin
        if (!applied && !modelQ[i].complete) begin
          modelQ[i].rdWdata  = ldRd;
          modelQ[i].memRdata = ldMem;
          modelQ[i].complete = 1'b1;
          applied = 1'b1;
        end
      end
      if (!applied && acc && inP.pending) begin
        inP.rdWdata  = ldRd;
        inP.memRdata = ldMem;
        inP.complete = 1'b1;
        applied = 1'b1;
      end
      if (!applied) modelErr = 1'b1;
    end
    if (acc) modelQ.push_back(inP);
    expValid = 1'b0;
    if (modelQ.size() > 0 && modelQ[0].complete) begin
      expPkt        = modelQ.pop_front();
      expOrder      = modelOrder;
      modelOrder    = modelOrder + 64'd1;
      expIntr       = INTR_EN && modelLastTrap;
      modelLastTrap = expPkt.trap;
      expValid      = 1'b1;
    end
    expReady = (modelQ.size() < DEPTH);
  endtask

  // Compare every collector output against the model's expectation.
  task automatic checkAll();
    checkOutput("rand valid", rvfi_valid, expValid);
    checkOutput("rand order", rvfi_order, expOrder);
    checkOutput("rand insn", rvfi_insn, expPkt.insn);
    checkOutput("rand trap", rvfi_trap, expPkt.trap);
    checkOutput("rand halt", rvfi_halt, expPkt.halt);
    checkOutput("rand intr", rvfi_intr, expIntr);
    checkOutput("rand mode", rvfi_mode, expPkt.mode);
    checkOutput("rand ixl", rvfi_ixl, 2'b01);
    checkOutput("rand rs1_addr", rvfi_rs1_addr, expPkt.rs1Addr);
    checkOutput("rand rs2_addr", rvfi_rs2_addr, expPkt.rs2Addr);
    checkOutput("rand rd_addr", rvfi_rd_addr, expPkt.rdAddr);
    checkOutput("rand rs1_rdata", rvfi_rs1_rdata, expPkt.rs1Rdata);
    checkOutput("rand rs2_rdata", rvfi_rs2_rdata, expPkt.rs2Rdata);
    checkOutput("rand rd_wdata", rvfi_rd_wdata, expPkt.rdWdata);
    checkOutput("rand pc_rdata", rvfi_pc_rdata, expPkt.pcRdata);
    checkOutput("rand pc_wdata", rvfi_pc_wdata, expPkt.pcWdata);
    checkOutput("rand mem_addr", rvfi_mem_addr, expPkt.memAddr);
    checkOutput("rand mem_rmask", rvfi_mem_rmask, expPkt.memRmask);
    checkOutput("rand mem_wmask", rvfi_mem_wmask, expPkt.memWmask);
    checkOutput("rand mem_rdata", rvfi_mem_rdata, expPkt.memRdata);
    checkOutput("rand mem_wdata", rvfi_mem_wdata, expPkt.memWdata);
    checkOutput("rand proto_err", proto_err, modelErr);
    checkOutput("rand ready after", ret_ready, expReady);
  endtask

  // Main test sequence: directed table, hand-written corner cases, then random traffic.
  initial begin
    vec_t vecs[11];
    pkt_t idle;
    pkt_t p;
    bit   v;
    bit   ldv;
    bit   hasPending;
    logic [31:0] ldm;
    logic [31:0] ldr;

    idle = '{default: '0};

    vecs[0]  = '{1, 0, 32'h00, 0, 32'h0,        1, 32'h00, 64'd0, 32'h1000_0000, 1};
    vecs[1]  = '{1, 0, 32'h04, 0, 32'h0,        1, 32'h04, 64'd1, 32'h1000_0004, 1};
    vecs[2]  = '{1, 0, 32'h08, 0, 32'h0,        1, 32'h08, 64'd2, 32'h1000_0008, 1};
    vecs[3]  = '{0, 0, 32'h00, 0, 32'h0,        0, 32'h08, 64'd2, 32'h1000_0008, 1};
    vecs[4]  = '{1, 1, 32'h10, 0, 32'h0,        0, 32'h08, 64'd2, 32'h1000_0008, 1};
    vecs[5]  = '{1, 0, 32'h14, 0, 32'h0,        0, 32'h08, 64'd2, 32'h1000_0008, 1};
    vecs[6]  = '{0, 0, 32'h00, 0, 32'h0,        0, 32'h08, 64'd2, 32'h1000_0008, 1};
    vecs[7]  = '{0, 0, 32'h00, 0, 32'h0,        0, 32'h08, 64'd2, 32'h1000_0008, 1};
    vecs[8]  = '{0, 0, 32'h00, 1, 32'hDEADBEEF, 1, 32'h10, 64'd3, 32'hDEADBEEF,   1};
    vecs[9]  = '{0, 0, 32'h00, 0, 32'h0,        1, 32'h14, 64'd4, 32'h1000_0014, 1};
    vecs[10] = '{0, 0, 32'h00, 0, 32'h0,        0, 32'h14, 64'd4, 32'h1000_0014, 1};

    $display("[TB] starting rvfi_collector bench, DEPTH=%0d INTR_EN=%0d", DEPTH, INTR_EN);
    applyReset();

    // Directed table: three back-to-back retires, then a late load blocking a younger add.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].v) p = mkPkt(vecs[i].pc, vecs[i].pend, 1'b0);
      else p = idle;
      applyStimulus(vecs[i].v, p, vecs[i].ldv, ~vecs[i].ldRd, vecs[i].ldRd);
      tick();
      checkOutput($sformatf("vec%0d valid", i), rvfi_valid, vecs[i].expValid);
      checkOutput($sformatf("vec%0d pc_rdata", i), rvfi_pc_rdata, vecs[i].expPc);
      checkOutput($sformatf("vec%0d order", i), rvfi_order, vecs[i].expOrder);
      checkOutput($sformatf("vec%0d rd_wdata", i), rvfi_rd_wdata, vecs[i].expRd);
      checkOutput($sformatf("vec%0d ready", i), ret_ready, vecs[i].expReady);
    end
    checkOutput("vec proto_err", proto_err, 1'b0);

    // Full queue: four pending loads, then ret_valid held high against a full queue.
    applyReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, mkPkt(32'h40 + 32'(i * 4), 1'b1, 1'b0), 1'b0, 32'd0, 32'd0);
      tick();
      checkOutput($sformatf("full fill%0d ready", i), ret_ready, (i < 3) ? 1'b1 : 1'b0);
      checkOutput($sformatf("full fill%0d valid", i), rvfi_valid, 1'b0);
    end
    applyStimulus(1'b1, mkPkt(32'h80, 1'b0, 1'b0), 1'b0, 32'd0, 32'd0);
    tick();
    checkOutput("full hold ready", ret_ready, 1'b0);
    checkOutput("full hold valid", rvfi_valid, 1'b0);
    applyStimulus(1'b1, mkPkt(32'h80, 1'b0, 1'b0), 1'b1, 32'h5555_0000, 32'hA0A0_0000);
    tick();
    checkOutput("full drain0 valid", rvfi_valid, 1'b1);
    checkOutput("full drain0 pc", rvfi_pc_rdata, 32'h40);
    checkOutput("full drain0 rd", rvfi_rd_wdata, 32'hA0A0_0000);
    checkOutput("full drain0 memrd", rvfi_mem_rdata, 32'h5555_0000);
    checkOutput("full drain0 ready", ret_ready, 1'b1);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b0, idle, 1'b1, 32'h5555_0000, 32'hA0A0_0000 + 32'(i));
      tick();
      checkOutput($sformatf("full drain%0d valid", i), rvfi_valid, 1'b1);
      checkOutput($sformatf("full drain%0d pc", i), rvfi_pc_rdata, 32'h40 + 32'(i * 4));
      checkOutput($sformatf("full drain%0d order", i), rvfi_order, 64'(i));
      checkOutput($sformatf("full drain%0d rd", i), rvfi_rd_wdata, 32'hA0A0_0000 + 32'(i));
    end
    applyStimulus(1'b0, idle, 1'b0, 32'd0, 32'd0);
    tick();
    checkOutput("full idle valid", rvfi_valid, 1'b0);
    checkOutput("full proto_err", proto_err, 1'b0);

    // Stray load data with an empty queue sets the sticky error flag.
    applyReset();
    applyStimulus(1'b0, idle, 1'b1, 32'h1, 32'h2);
    tick();
    checkOutput("stray proto_err", proto_err, 1'b1);
    checkOutput("stray valid", rvfi_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, idle, 1'b0, 32'd0, 32'd0);
      tick();
      checkOutput($sformatf("stray sticky%0d", i), proto_err, 1'b1);
      checkOutput($sformatf("stray valid%0d", i), rvfi_valid, 1'b0);
    end

    // Reset with two pending entries: nothing survives and order restarts at 0.
    applyReset();
    applyStimulus(1'b1, mkPkt(32'h200, 1'b0, 1'b0), 1'b0, 32'd0, 32'd0);
    tick();
    checkOutput("midrst first valid", rvfi_valid, 1'b1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, mkPkt(32'h204 + 32'(i * 4), 1'b1, 1'b0), 1'b0, 32'd0, 32'd0);
      tick();
    end
    checkOutput("midrst held pc", rvfi_pc_rdata, 32'h200);
    applyReset();
    applyStimulus(1'b0, idle, 1'b1, 32'h7, 32'h9);
    tick();
    checkOutput("midrst ld proto_err", proto_err, 1'b1);
    checkOutput("midrst ld valid", rvfi_valid, 1'b0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, idle, 1'b0, 32'd0, 32'd0);
      tick();
      checkOutput($sformatf("midrst quiet%0d", i), rvfi_valid, 1'b0);
    end
    applyStimulus(1'b1, mkPkt(32'h300, 1'b0, 1'b0), 1'b0, 32'd0, 32'd0);
    tick();
    checkOutput("midrst post valid", rvfi_valid, 1'b1);
    checkOutput("midrst post order", rvfi_order, 64'd0);
    checkOutput("midrst post pc", rvfi_pc_rdata, 32'h300);

    // Trap followed by a handler: the handler packet carries the interrupt flag when enabled.
    applyReset();
    applyStimulus(1'b1, mkPkt(32'h20, 1'b0, 1'b1), 1'b0, 32'd0, 32'd0);
    tick();
    checkOutput("intr trap valid", rvfi_valid, 1'b1);
    checkOutput("intr trap trap", rvfi_trap, 1'b1);
    checkOutput("intr trap intr", rvfi_intr, 1'b0);
    applyStimulus(1'b1, mkPkt(32'h100, 1'b0, 1'b0), 1'b0, 32'd0, 32'd0);
    tick();
    checkOutput("intr handler pc", rvfi_pc_rdata, 32'h100);
    checkOutput("intr handler intr", rvfi_intr, INTR_EN);
    applyStimulus(1'b1, mkPkt(32'h104, 1'b0, 1'b0), 1'b0, 32'd0, 32'd0);
    tick();
    checkOutput("intr third pc", rvfi_pc_rdata, 32'h104);
    checkOutput("intr third intr", rvfi_intr, 1'b0);

    // Random traffic against the queue model, with one reset in the middle.
    applyReset();
    modelReset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        applyReset();
        modelReset();
      end
      p = randPkt();
      v = ($urandom_range(0, 3) != 0);
      hasPending = v && p.pending;
      foreach (modelQ[i]) if (!modelQ[i].complete) hasPending = 1'b1;
      ldv = hasPending ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
      ldm = $urandom;
      ldr = $urandom;
      applyStimulus(v, p, ldv, ldm, ldr);
      modelStep(v, p, ldv, ldm, ldr);
      tick();
      checkAll();
    end

    applyStimulus(1'b0, idle, 1'b0, 32'd0, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
